controller_multi_cycle: RTL and testbench
=========================================

# controller_multi_cycle

Moore-style main controller for the multi-cycle RV32I core. It sequences one shared ALU, one unified instruction/data memory, and the IR, PC, ALUOut and data registers through fetch, decode and execute states. It decodes opcode, funct3 and funct7[5] and issues every datapath enable and mux select. It covers the same instruction subset as the single-cycle core.

## Interface
Parameters:
- none (all encodings live in the shared package)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2 from the ALU compare
- pc_write  out  1  PC load enable
- ir_write  out  1  IR and OldPC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  memory write enable
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = imm, 10 = constant 4
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- result_src  out  2  result select: 00 = ALUOut, 01 = data register, 10 = live ALU result, 11 = imm
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- instr_done  out  1  one-cycle pulse in the final state of each instruction

## Operation
- State register resets asynchronously to FETCH.
- While rst = 1, every output is forced to 0.
- Outputs not listed for a state are 0, except alu_control, which defaults to add.
- imm_src is combinational from opcode in every state; unknown opcodes give 000.
- States, their outputs (->) and next state (=>):
  - FETCH: adr_src 0, ir_write, A = PC, B = 4, add, result_src 10, pc_write => DECODE.
  - DECODE: A = OldPC, B = imm, add (ALUOut gets the branch/jal target). Next state by opcode:
    - 3 or 35 => MEM_ADR
    - 51 => EXEC_R
    - 19 => EXEC_I
    - 99 => BRANCH
    - 111 => JUMP
    - 103 => JALR_ADR
    - 55 => LUI
    - any other => FETCH (treated as a nop; instr_done pulses)
  - MEM_ADR: A = rs1, B = imm, add => MEM_READ if opcode = 3, else MEM_WRITE.
  - MEM_READ: result_src 00, adr_src 1 => MEM_WB.
  - MEM_WB: result_src 01, reg_write, instr_done => FETCH.
  - MEM_WRITE: result_src 00, adr_src 1, mem_write, instr_done => FETCH.
  - EXEC_R: A = rs1, B = rs2, ALU op from R decode => ALU_WB.
  - EXEC_I: A = rs1, B = imm, ALU op from I decode => ALU_WB.
  - ALU_WB: result_src 00, reg_write, instr_done => FETCH.
  - BRANCH: A = rs1, B = rs2, sub, result_src 00, pc_write = taken, instr_done => FETCH.
  - JALR_ADR: A = rs1, B = imm, add (ALUOut gets the target) => JUMP.
  - JUMP: A = OldPC, B = 4, add, result_src 00, pc_write (ALUOut gets the link value) => ALU_WB.
  - LUI: result_src 11, reg_write, instr_done => FETCH.
- R decode (funct3 / funct7_5):
  - 000/0 add, 000/1 sub
  - 111 and, 110 or, 100 xor
  - 010 slt, 011 sltu
  - anything else: add
- I decode:
  - 000 add (funct7_5 ignored)
  - 111 and, 110 or, 100 xor
  - 010 slt, 011 sltu
  - anything else: add
- Branch taken:
  - funct3 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - other funct3: not taken

## Timing
- Cycles per instruction, counted from FETCH to the cycle with instr_done:
  - lw 5, jalr 5
  - sw 4, R-type 4, I-type 4, jal 4
  - branch 3, lui 3
  - illegal opcode 2
- Outputs are combinational from state, opcode, funct and flags; there are no registered outputs.
- Datapath registers load on the edge that ends the asserting state.
- jalr with rd = rs1 is correct, because rs1 is latched in the A register during DECODE.
- rst asserted mid-instruction: state is FETCH immediately and outputs are 0. No partial write may occur once rst is high.
- After rst is released, the first clock edge completes FETCH.

## Structure
- Package controller_multi_cycle_pkg holds:
  - state enum
  - opcode constants (3, 19, 35, 51, 55, 99, 103, 111)
  - alu_control codes
  - alu_src_a, alu_src_b, result_src and imm_src codes
- Sub-module alu_decoder: combinational. Inputs are mode (R / I / add / sub), funct3 and funct7_5; output is alu_control.

## Test plan
- Reset: hold rst = 1 with opcode 51.
  - Required: all outputs 0.
  - Release rst: FETCH, with pc_write = 1, ir_write = 1, alu_src_b = 10.
- Fetch sub x5,x6,x7 (opcode 51, funct3 000, funct7_5 1).
  - Required: states FETCH, DECODE, EXEC_R (alu_control 001), ALU_WB (reg_write, instr_done). 4 cycles.
- Fetch lw then sw.
  - lw: 5 cycles. MEM_READ has adr_src 1; MEM_WB has result_src 01 and reg_write.
  - sw: 4 cycles. MEM_WRITE has mem_write 1 and reg_write 0.
- Branches:
  - bne with zero = 0: pc_write 1 in BRANCH.
  - beq with zero = 0: pc_write 0.
  - bge with lt = 1: pc_write 0.
  - funct3 010: pc_write 0.
  - All four take 3 cycles.
- Jumps:
  - jalr (opcode 103): JALR_ADR (A = 10, B = 01), JUMP (pc_write, result_src 00), ALU_WB. 5 cycles.
  - jal: skips JALR_ADR. 4 cycles.
- Edge cases:
  - Opcode 0x7F returns to FETCH after DECODE with no write enables. 2 cycles.
  - rst pulsed during MEM_WRITE: mem_write drops to 0 immediately and the next state is FETCH.

Source files
------------

// File: rtl/controller_multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller:
// controller states, opcode constants, ALU operation codes, datapath mux
// select codes and the immediate-format lookup used by the controller.
package controller_multi_cycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JALR_ADR,
        S_JUMP,
        S_LUI
    } state_t;

    // How the ALU decoder should pick the operation.
    typedef enum logic [1:0] {
        MODE_ADD,
        MODE_SUB,
        MODE_R,
        MODE_I
    } alu_mode_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_OPIMM  = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_OP     = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format from opcode alone; R-type and unknown opcodes fall to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/controller_multi_cycle_alu_decoder.sv
// ALU operation decoder.
//   mode     : MODE_ADD / MODE_SUB force the op; MODE_R / MODE_I decode funct
//   funct3   : IR[14:12]
//   funct7_5 : IR[30], only selects sub for R-type funct3 000
//   alu_control : ALU operation code
module alu_decoder
    import controller_multi_cycle_pkg::*;
(
    input  alu_mode_t  mode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (mode)
            MODE_SUB: alu_control = ALU_SUB;
            MODE_R, MODE_I: begin
                case (funct3)
                    // addi has no sub form, so funct7_5 only matters for R-type.
                    3'b000:  alu_control = (mode == MODE_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/controller_multi_cycle.sv
// Moore main controller for the multi-cycle RV32I core.
// Inputs : clk, rst (async, active high), opcode/funct3/funct7_5 from IR,
//          zero/lt flags from the ALU compare.
// Outputs: PC/IR/memory/register-file enables, ALU source selects,
//          alu_control, result_src, imm_src and an instr_done pulse in the
//          last state of every instruction. All outputs are 0 while rst = 1.
module controller_multi_cycle
    import controller_multi_cycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       instr_done
);

    state_t     state_q, state_d;
    alu_mode_t  alu_mode;
    logic [2:0] alu_dec;
    logic       taken;
    logic       pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write_c, done_c;
    logic [1:0] src_a_c, src_b_c, result_c;

    alu_decoder u_alu_decoder (
        .mode        (alu_mode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        adr_src_c   = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        done_c      = 1'b0;
        src_a_c     = SRCA_PC;
        src_b_c     = SRCB_RS2;
        result_c    = RES_ALUOUT;
        alu_mode    = MODE_ADD;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR loads.
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                src_a_c    = SRCA_PC;
                src_b_c    = SRCB_FOUR;
                result_c   = RES_ALU;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Precompute OldPC+imm so branch/jal find their target in ALUOut.
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_OP:             state_d = S_EXEC_R;
                    OP_OPIMM:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JUMP;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        state_d = S_FETCH;
                        done_c  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src_c = 1'b1;
                state_d   = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_c    = RES_DATA;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_EXEC_R: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_RS2;
                alu_mode = MODE_R;
                state_d  = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_IMM;
                alu_mode = MODE_I;
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BRANCH: begin
                // ALU compares rs1-rs2 for the flags; ALUOut still holds the target.
                src_a_c    = SRCA_RS1;
                src_b_c    = SRCB_RS2;
                alu_mode   = MODE_SUB;
                pc_write_c = taken;
                done_c     = 1'b1;
            end
            S_JALR_ADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = S_JUMP;
            end
            S_JUMP: begin
                // PC takes the target from ALUOut; ALU builds OldPC+4 as the link.
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = S_ALU_WB;
            end
            S_LUI: begin
                result_c    = RES_IMM;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Gate every output with rst so no write can slip out while in reset.
    always_comb begin
        pc_write    = !rst && pc_write_c;
        ir_write    = !rst && ir_write_c;
        adr_src     = !rst && adr_src_c;
        mem_write   = !rst && mem_write_c;
        reg_write   = !rst && reg_write_c;
        instr_done  = !rst && done_c;
        alu_src_a   = rst ? 2'b00 : src_a_c;
        alu_src_b   = rst ? 2'b00 : src_b_c;
        result_src  = rst ? 2'b00 : result_c;
        alu_control = rst ? 3'b000 : alu_dec;
        imm_src     = rst ? 3'b000 : imm_src_of(opcode);
    end

endmodule

// File: tb/tb_controller_multi_cycle.sv
module tb_controller_multi_cycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd51;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, instr_done;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] obs;

    controller_multi_cycle dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
        .imm_src(imm_src), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, alu_src_b,
                  alu_control, result_src, imm_src, instr_done};

    // ---------------- reference model (instruction level) ----------------
    function automatic bit m_legal(input logic [6:0] op);
        return op == 3 || op == 19 || op == 35 || op == 51 || op == 55 ||
               op == 99 || op == 103 || op == 111;
    endfunction

    function automatic logic [2:0] m_imm(input logic [6:0] op);
        if (op == 35)  return 3'd1;
        if (op == 99)  return 3'd2;
        if (op == 111) return 3'd3;
        if (op == 55)  return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] m_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd2:    return 3'd5;
            3'd3:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit m_taken(input logic [2:0] f3, input logic z, input logic l);
        if (f3 == 0) return z;
        if (f3 == 1) return !z;
        if (f3 == 4) return l;
        if (f3 == 5) return !l;
        return 1'b0;
    endfunction

    function automatic logic [17:0] mk(input bit pw, input bit irw, input bit adr, input bit mw,
                                       input bit rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] rs,
                                       input logic [2:0] im, input bit done);
        return {pw, irw, adr, mw, rw, a, b, alu, rs, im, done};
    endfunction

    // Expected per-cycle output vectors for one whole instruction.
    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic z, input logic l);
        logic [2:0] im;
        im = m_imm(op);
        exp_q.delete();
        exp_q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 2'b10, 3'd0, 2'b10, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd0, 2'b00, im, !m_legal(op)));
        case (op)
            7'd3: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00, im, 0));
                exp_q.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, im, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b01, im, 1));
            end
            7'd35: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00, im, 0));
                exp_q.push_back(mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 3'd0, 2'b00, im, 1));
            end
            7'd51, 7'd19: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, (op == 51) ? 2'b00 : 2'b01,
                                   m_alu(op == 51, f3, f7), 2'b00, im, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b00, im, 1));
            end
            7'd99:
                exp_q.push_back(mk(m_taken(f3, z, l), 0, 0, 0, 0, 2'b10, 2'b00, 3'd1, 2'b00, im, 1));
            7'd103, 7'd111: begin
                if (op == 103)
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00, im, 0));
                exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'd0, 2'b00, im, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b00, im, 1));
            end
            7'd55:
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b11, im, 1));
            default: ;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input logic [17:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered just after a posedge with the controller in FETCH.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input string tag);
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z; lt = l;
        build(op, f3, f7, z, l);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check(exp_q[i], $sformatf("%s_cyc%0d", tag, i));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        ops = '{7'd3, 7'd19, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111, 7'd127};

        // Reset held with an R-type opcode on the IR.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(18'd0, "reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;

        run(7'd51, 3'd0, 1'b1, 0, 0, "sub");
        run(7'd3,  3'd2, 1'b0, 0, 0, "lw");
        run(7'd35, 3'd2, 1'b0, 0, 0, "sw");
        run(7'd99, 3'd1, 1'b0, 0, 0, "bne_taken");
        run(7'd99, 3'd0, 1'b0, 0, 0, "beq_not");
        run(7'd99, 3'd5, 1'b0, 0, 1, "bge_not");
        run(7'd99, 3'd2, 1'b0, 1, 1, "br_f3_010");
        run(7'd103, 3'd0, 1'b0, 0, 0, "jalr");
        run(7'd111, 3'd0, 1'b0, 0, 0, "jal");
        run(7'd127, 3'd0, 1'b0, 0, 0, "illegal");
        run(7'd55, 3'd3, 1'b1, 0, 0, "lui");
        run(7'd19, 3'd0, 1'b1, 0, 0, "addi_f7");
        run(7'd51, 3'd5, 1'b0, 0, 0, "r_f3_101");

        // Reset pulse in the middle of MEM_WRITE.
        opcode = 7'd35; funct3 = 3'd2; funct7_5 = 1'b0;
        build(7'd35, 3'd2, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(exp_q[i], $sformatf("swrst_cyc%0d", i));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check(exp_q[3], "swrst_memwrite");
        #1 rst = 1'b1;
        #1 check(18'd0, "swrst_outputs_zero");
        @(posedge clk);
        #1 rst = 1'b0;
        run(7'd51, 3'd7, 1'b0, 0, 0, "after_rst_and");

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 7'd127) begin
                op = 7'($urandom_range(0, 127));
                while (m_legal(op)) op = 7'($urandom_range(0, 127));
            end
            run(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
